// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmitter slice.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_tx_if.sv
// Parallel-request / serial-line bundle between the controller and the UART transmitter.
interface uart_tx_if #(
  parameter int DATA_WIDTH = 8
);

  logic [DATA_WIDTH-1:0] i_p_data;
  logic                  i_data_valid;
  logic                  i_par_en;
  logic                  i_par_typ;
  logic                  o_tx_out;
  logic                  o_busy;

  modport master (
    output i_p_data,
    output i_data_valid,
    output i_par_en,
    output i_par_typ,
    input  o_tx_out,
    input  o_busy
  );

  modport slave (
    input  i_p_data,
    input  i_data_valid,
    input  i_par_en,
    input  i_par_typ,
    output o_tx_out,
    output o_busy
  );

endinterface

// File: rtl/uart_tx_serializer.sv
// Load-enabled right-shift register with a bit counter; o_done flags the last payload bit.
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_W      = $clog2(DATA_WIDTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_load,
  input  logic                  i_shift,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_cur_bit,
  output logic                  o_nxt_bit,
  output logic                  o_done
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] shift_r;
  logic [CNT_W-1:0]      cnt_r;

  // Shift register and bit index of the payload bit currently on the line.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      shift_r <= '0;
      cnt_r   <= '0;
    end else if (i_load) begin
      shift_r <= i_data;
      cnt_r   <= '0;
    end else if (i_shift) begin
      shift_r <= {1'b0, shift_r[DATA_WIDTH-1:1]};
      cnt_r   <= cnt_r + CNT_W'(1);
    end else begin
      shift_r <= shift_r;
      cnt_r   <= cnt_r;
    end
  end

  assign o_cur_bit = shift_r[0];
  assign o_nxt_bit = shift_r[1];
  assign o_done    = (cnt_r == CNT_LAST);

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter: start, LSB-first data, optional parity, stop; outputs straight from flops.
// Define UART_TX_TWO_STOP_EN to stretch the stop bit to two bit times.
module uart_tx_core
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic    i_clk,
  input  logic    i_rst_n,
  uart_tx_if.slave tx_if
);

`ifdef UART_TX_TWO_STOP_EN
  localparam logic STOP_LAST = 1'b1;
`else
  localparam logic STOP_LAST = 1'b0;
`endif

  tx_state_e state_r, state_nxt_s;
  logic      tx_out_r, tx_nxt_s;
  logic      busy_r, busy_nxt_s;
  logic      par_en_r, par_bit_r, stop_cnt_r;
  logic      load_s, shift_s;
  logic      cur_bit_s, nxt_bit_s, done_s;

  function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] data, input logic typ);
    return (^data) ^ (typ == PAR_ODD);
  endfunction

  uart_tx_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_ser (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_load   (load_s),
    .i_shift  (shift_s),
    .i_data   (tx_if.i_p_data),
    .o_cur_bit(cur_bit_s),
    .o_nxt_bit(nxt_bit_s),
    .o_done   (done_s)
  );

  // Next state plus next line/busy values, so the output flops track the state exactly.
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    shift_s     = 1'b0;
    tx_nxt_s    = STOP_BIT;
    busy_nxt_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (tx_if.i_data_valid) begin
          state_nxt_s = START;
          load_s      = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      START:  state_nxt_s = DATA;
      DATA: begin
        if (done_s) begin
          state_nxt_s = par_en_r ? PARITY : STOP;
        end else begin
          shift_s = 1'b1;
        end
      end
      PARITY: state_nxt_s = STOP;
      STOP: begin
        if (stop_cnt_r == STOP_LAST) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = STOP;
        end
      end
      default: state_nxt_s = IDLE;
    endcase

    case (state_nxt_s)
      IDLE:    begin tx_nxt_s = STOP_BIT;  busy_nxt_s = 1'b0; end
      START:   begin tx_nxt_s = START_BIT; busy_nxt_s = 1'b1; end
      DATA:    begin tx_nxt_s = (state_r == DATA) ? nxt_bit_s : cur_bit_s; busy_nxt_s = 1'b1; end
      PARITY:  begin tx_nxt_s = par_bit_r; busy_nxt_s = 1'b1; end
      STOP:    begin tx_nxt_s = STOP_BIT;  busy_nxt_s = 1'b1; end
      default: begin tx_nxt_s = STOP_BIT;  busy_nxt_s = 1'b0; end
    endcase
  end

  // State, registered outputs and per-frame latched parity controls.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_r    <= IDLE;
      tx_out_r   <= STOP_BIT;
      busy_r     <= 1'b0;
      par_en_r   <= 1'b0;
      par_bit_r  <= 1'b0;
      stop_cnt_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      tx_out_r   <= tx_nxt_s;
      busy_r     <= busy_nxt_s;
      stop_cnt_r <= (state_r == STOP) ? ~stop_cnt_r : 1'b0;
      if (load_s) begin
        par_en_r  <= tx_if.i_par_en;
        par_bit_r <= parity_bit(tx_if.i_p_data, tx_if.i_par_typ);
      end else begin
        par_en_r  <= par_en_r;
        par_bit_r <= par_bit_r;
      end
    end
  end

  assign tx_if.o_tx_out = tx_out_r;
  assign tx_if.o_busy   = busy_r;

endmodule

// File: tb/tb_uart_tx_core.sv
// Self-checking bench for uart_tx_core: directed frames plus randomized frames against a frame-list model.
module tb_uart_tx_core;

  localparam int DW = 8;
`ifdef UART_TX_TWO_STOP_EN
  localparam int N_STOP = 2;
`else
  localparam int N_STOP = 1;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int tests_run    = 0;
  int tests_failed = 0;
  bit exp_q[$];

  uart_tx_if #(.DATA_WIDTH(DW)) tx_if ();

  uart_tx_core #(.DATA_WIDTH(DW)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .tx_if  (tx_if)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_idle_line"}, {31'd0, tx_if.o_tx_out}, 32'd1);
    check_eq({tag, "_idle_busy"}, {31'd0, tx_if.o_busy}, 32'd0);
  endtask

  // Reference frame: start, data LSB first, optional parity, stop bit(s).
  task automatic build_frame(input logic [DW-1:0] d, input bit pe, input bit pt);
    int ones;
    ones = 0;
    exp_q.delete();
    exp_q.push_back(1'b0);
    for (int i = 0; i < DW; i++) begin
      exp_q.push_back(((d >> i) & 1) != 0);
      ones += ((d >> i) & 1);
    end
    if (pe) begin
      if (pt) exp_q.push_back((ones % 2) == 0);
      else    exp_q.push_back((ones % 2) == 1);
    end
    for (int s = 0; s < N_STOP; s++) exp_q.push_back(1'b1);
  endtask

  // Called just after the accepting edge; ends on the first post-frame cycle.
  task automatic expect_frame(input logic [DW-1:0] d, input bit pe, input bit pt,
                              input bit scramble, input string tag);
    int n;
    build_frame(d, pe, pt);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      check_eq($sformatf("%s_line%0d", tag, i), {31'd0, tx_if.o_tx_out}, {31'd0, exp_q[i]});
      check_eq($sformatf("%s_busy%0d", tag, i), {31'd0, tx_if.o_busy}, 32'd1);
      if (scramble && i == 1) begin
        tx_if.i_p_data     = DW'($urandom_range(0, 255));
        tx_if.i_par_en     = 1'($urandom_range(0, 1));
        tx_if.i_par_typ    = 1'($urandom_range(0, 1));
        tx_if.i_data_valid = 1'b1;
      end
      if (scramble && i == n - 1) tx_if.i_data_valid = 1'b0;
      tick();
    end
    check_idle(tag);
  endtask

  task automatic send(input logic [DW-1:0] d, input bit pe, input bit pt,
                      input bit scramble, input string tag);
    tx_if.i_p_data     = d;
    tx_if.i_par_en     = pe;
    tx_if.i_par_typ    = pt;
    tx_if.i_data_valid = 1'b1;
    tick();
    tx_if.i_data_valid = 1'b0;
    expect_frame(d, pe, pt, scramble, tag);
  endtask

  initial begin
    logic [DW-1:0] rd;
    bit rpe, rpt;
    int gap;

    tx_if.i_p_data     = '0;
    tx_if.i_data_valid = 1'b0;
    tx_if.i_par_en     = 1'b0;
    tx_if.i_par_typ    = 1'b0;

    rst_n = 1'b0;
    tick();
    tick();
    check_idle("reset");
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_idle($sformatf("post_reset%0d", i));
    end

    send(8'hA5, 1'b0, 1'b0, 1'b0, "a5");
    send(8'h07, 1'b1, 1'b0, 1'b0, "07_even");
    send(8'h07, 1'b1, 1'b1, 1'b0, "07_odd");

    // Valid held high: second word staged mid-frame, taken after exactly one idle cycle.
    tx_if.i_p_data     = 8'h3C;
    tx_if.i_par_en     = 1'b0;
    tx_if.i_par_typ    = 1'b0;
    tx_if.i_data_valid = 1'b1;
    tick();
    tx_if.i_p_data = 8'hC3;
    expect_frame(8'h3C, 1'b0, 1'b0, 1'b0, "b2b_first");
    tick();
    tx_if.i_data_valid = 1'b0;
    expect_frame(8'hC3, 1'b0, 1'b0, 1'b0, "b2b_second");

    // Reset while data bit 4 is on the line.
    tx_if.i_p_data     = 8'h96;
    tx_if.i_data_valid = 1'b1;
    tick();
    tx_if.i_data_valid = 1'b0;
    build_frame(8'h96, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check_eq($sformatf("abort_line%0d", i), {31'd0, tx_if.o_tx_out}, {31'd0, exp_q[i]});
      tick();
    end
    rst_n = 1'b0;
    tick();
    check_idle("abort_edge");
    rst_n = 1'b1;
    tick();
    check_idle("abort_after");
    send(8'h55, 1'b0, 1'b0, 1'b0, "after_abort");

    send(8'hFF, 1'b1, 1'b1, 1'b0, "ff_odd");

    for (int k = 0; k < 24; k++) begin
      rd  = DW'($urandom_range(0, 255));
      rpe = 1'($urandom_range(0, 1));
      rpt = 1'($urandom_range(0, 1));
      send(rd, rpe, rpt, 1'b1, $sformatf("rnd%0d", k));
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        tick();
        check_idle($sformatf("rnd%0d_gap%0d", k, g));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
